// File: rtl/cond_eval_unit.sv
// Status-flag register and ARM-style condition evaluator with branch select.
// Optional build macro CC_FORWARD_EN forwards cc_in into the check while S=1.
module cond_eval_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cc_in,
    input  logic       S,
    input  logic [3:0] instr_condition,
    input  logic       b_instr,
    output logic [3:0] cc_out,
    output logic       asserted,
    output logic       choose_ta_r_nop
);

    logic [3:0] flags_eval;

    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic hit;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: hit = z;
            4'b0001: hit = !z;
            4'b0010: hit = c;
            4'b0011: hit = !c;
            4'b0100: hit = n;
            4'b0101: hit = !n;
            4'b0110: hit = v;
            4'b0111: hit = !v;
            4'b1000: hit = c & !z;
            4'b1001: hit = !c | z;
            4'b1010: hit = (n == v);
            4'b1011: hit = (n != v);
            4'b1100: hit = !z & (n == v);
            4'b1101: hit = z | (n != v);
            4'b1110: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Status register: 1-cycle write latency, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_out <= 4'b0000;
        end else if (S) begin
            cc_out <= cc_in;
        end
    end

`ifdef CC_FORWARD_EN
    // Same-cycle ALU flags win over the stored copy while they are being written
    assign flags_eval = S ? cc_in : cc_out;
`else
    assign flags_eval = cc_out;
`endif

    assign asserted        = eval_cond(instr_condition, flags_eval);
    assign choose_ta_r_nop = asserted & b_instr;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Scoreboard bench for cond_eval_unit: stimulus pushes expected values,
// a negedge monitor pops and compares. Honors CC_FORWARD_EN like the design.
module tb_cond_eval_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] cc_in;
    logic       S;
    logic [3:0] instr_condition;
    logic       b_instr;
    logic [3:0] cc_out;
    logic       asserted;
    logic       choose_ta_r_nop;

    typedef struct {
        logic [3:0] cc;
        logic       hit;
        logic       sel;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [3:0] model_flags;

    cond_eval_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cc_in           (cc_in),
        .S               (S),
        .instr_condition (instr_condition),
        .b_instr         (b_instr),
        .cc_out          (cc_out),
        .asserted        (asserted),
        .choose_ta_r_nop (choose_ta_r_nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conditions come in complementary pairs: bit 0 inverts the base test.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, k, v, base;
        n = f[3]; z = f[2]; k = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = k;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = k && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [3:0] eval_flags();
`ifdef CC_FORWARD_EN
        return S ? cc_in : model_flags;
`else
        return model_flags;
`endif
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        logic h;
        h = (rst_n === 1'b1 || rst_n === 1'b0) ? cond_holds(instr_condition, eval_flags()) : 1'b0;
        e.cc  = model_flags;
        e.hit = h;
        e.sel = h && b_instr;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One cycle: let the edge update the model, then apply new inputs.
    task automatic cyc(input logic r, input logic [3:0] cc, input logic s,
                       input logic [3:0] cond, input logic b, input string tag);
        @(posedge clk);
        if (!rst_n) model_flags = 4'b0000;
        else if (S) model_flags = cc_in;
        #1;
        rst_n = r; cc_in = cc; S = s; instr_condition = cond; b_instr = b;
        if (!rst_n) model_flags = 4'b0000;
        push_exp(tag);
    endtask

    task automatic async_drop(input string tag);
        @(posedge clk);
        if (!rst_n) model_flags = 4'b0000;
        else if (S) model_flags = cc_in;
        #1;
        S = 1'b0; instr_condition = 4'b0000; b_instr = 1'b1;
        #2;
        rst_n = 1'b0;
        model_flags = 4'b0000;
        push_exp(tag);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".cc_out"},   cc_out,                 e.cc);
            check({e.tag, ".asserted"}, {3'b000, asserted},       {3'b000, e.hit});
            check({e.tag, ".choose"},   {3'b000, choose_ta_r_nop}, {3'b000, e.sel});
        end
    end

    initial begin
        rst_n = 1'b0; cc_in = 4'hF; S = 1'b1; instr_condition = 4'b0000; b_instr = 1'b0;
        model_flags = 4'b0000;

        cyc(1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, "reset");
        cyc(1'b1, 4'hF, 1'b1, 4'b0000, 1'b0, "release");
        cyc(1'b1, 4'h0, 1'b0, 4'b1110, 1'b1, "write1111");
        cyc(1'b1, 4'h0, 1'b0, 4'b0000, 1'b0, "hold1111");

        // LT branch on flags 0011, taken and non-branch
        cyc(1'b1, 4'b0011, 1'b1, 4'b1011, 1'b1, "load0011");
        cyc(1'b1, 4'h0,    1'b0, 4'b1011, 1'b1, "lt_branch");
        cyc(1'b1, 4'h0,    1'b0, 4'b1011, 1'b0, "lt_nonbranch");

        // Exhaustive sweep of conditions x flags
        for (int f = 0; f < 16; f++) begin
            cyc(1'b1, f[3:0], 1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), "sweep_load");
            for (int c = 0; c < 16; c++)
                cyc(1'b1, 4'($urandom_range(15)), 1'b0, c[3:0], 1'($urandom_range(1)), "sweep");
        end

        // Forwarding: from 0000 write 0100 with EQ in the same cycle
        cyc(1'b0, 4'h0,    1'b0, 4'b0000, 1'b0, "fwd_clear");
        cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, "fwd_same");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, "fwd_after");

        // Asynchronous reset between edges with EQ on flags 0100
        async_drop("async_rst");
        cyc(1'b0, 4'hF, 1'b1, 4'b1010, 1'b1, "rst_held_s1");
        cyc(1'b1, 4'hA, 1'b1, 4'b1110, 1'b0, "rst_release_write");

        // Random traffic, occasional resets
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(31) != 0), 4'($urandom_range(15)), 1'($urandom_range(1)),
                4'($urandom_range(15)), 1'($urandom_range(1)), "random");

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
